range_operand_loader: RTL and testbench
=======================================

Name: range_operand_loader

Overview:
- Upstream feeder for the packed-nibble range-sum stage.
- Collects eight 4-bit operands serially over a valid/ready stream and packs them into one 32-bit word. Latches the 3-bit range bounds, then restarts the summing stage with a one-cycle kick pulse.
- Waits a fixed settle time, then captures the stage's 8-bit sum and presents it on a valid/ready result port.

Parameters:
- NIB_W, 4, width of one operand nibble.
- NIB_N, 8, operands per packed word. Index width is fixed at 3 bits.
- WAIT_CYCLES, 10, clocks from kick deassertion to sum capture. Must be >= 9, the worst-case summing latency.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  nibble available
- in_data  in  NIB_W  nibble value
- in_ready  out  1  nibble accepted when in_valid && in_ready
- lo_idx  in  3  range bound A, sampled with the last nibble
- hi_idx  in  3  range bound B, sampled with the last nibble
- word_out  out  NIB_W*NIB_N  packed operands; nibble k at bits [4k+3:4k]
- m_out  out  3  range bound to summing stage
- big_m_out  out  3  range bound to summing stage
- kick  out  1  one-cycle restart pulse, wired to the summing stage's active-high reset
- sum_in  in  8  summing stage result
- out_valid  out  1  result available
- out_data  out  8  captured sum
- out_ready  in  1  result consumed when out_valid && out_ready

Behaviour:
- Reset values:
  - State LOAD, nibble count 0.
  - word_out=0, m_out=0, big_m_out=0.
  - kick=0, out_valid=0, out_data=0.
  - in_ready=1 after reset release.
- State LOAD:
  - in_ready=1.
  - Each accepted nibble is written to slot cnt; cnt increments.
  - First accepted nibble goes to slot 0 (bits [3:0]).
  - On accepting the nibble at cnt=7: sample lo_idx into m_out and hi_idx into big_m_out, reset cnt to 0, go to KICK.
  - in_valid low: hold, no change.
- State KICK:
  - Exactly one cycle, kick=1, in_ready=0.
  - word_out, m_out and big_m_out are stable from this cycle until the next LOAD acceptance.
  - Go to WAIT with wait counter = WAIT_CYCLES-1.
- State WAIT:
  - kick=0, in_ready=0.
  - Counter decrements each cycle.
  - When the counter reaches 0: capture sum_in into out_data, set out_valid=1, go to HOLD.
- State HOLD:
  - out_valid=1, out_data stable, in_ready=0.
  - On out_ready: out_valid=0 next cycle, go to LOAD.
  - A nibble presented in the same cycle as out_ready is not accepted; in_ready rises the following cycle.
- word_out is updated in place during LOAD. Slots not yet rewritten keep their previous word's values; the downstream stage ignores them until kick.
- Range bounds are passed unordered (m_out=lo_idx, big_m_out=hi_idx). The summing stage handles either order.
- Equal bounds are legal; the sum is that single nibble.
- No overflow handling is needed: max sum 8*15=120 < 256.
- Reset mid-operation from any state:
  - Immediate return to reset values; a partially loaded word is discarded.
  - kick drops asynchronously.
  - A pending out_valid is lost.
- Latency: last nibble accept -> kick 1 cycle later -> out_valid exactly WAIT_CYCLES+1 cycles after kick.

Optional Feature:
- Macro LOADER_RANGE_SORT_EN.
- Defined: at the last-nibble sample, the smaller of lo_idx/hi_idx goes to m_out and the larger to big_m_out.
- Undefined: bounds are passed unchanged (m_out=lo_idx, big_m_out=hi_idx).
- The sum result is identical either way; only the port values differ.

Test Plan:
- Nibbles 1,2,...,8 back-to-back, lo=2, hi=5, bench model sums inclusive range:
  - word_out=0x87654321.
  - kick high for exactly 1 cycle.
  - out_valid 11 cycles after kick, out_data=0x12.
- Same data with lo=5, hi=2:
  - Macro off: m_out=5, big_m_out=2.
  - Macro on: m_out=2, big_m_out=5.
  - out_data=0x12 in both cases.
- All nibbles 0xF, lo=0, hi=7 -> out_data=0x78 (120).
- in_valid toggling every other cycle -> only handshaked nibbles stored; kick follows the 8th accept.
- Hold out_ready low 5 cycles in HOLD:
  - out_valid and out_data stay stable, in_ready=0.
  - Raise out_ready with in_valid high -> that nibble is not taken; accepted next cycle into slot 0.
- Assert rst after 4 nibbles accepted -> all outputs return to reset values; the next 8 nibbles form a fresh word from slot 0.

Source files
------------

// File: rtl/range_operand_loader.sv
// range_operand_loader: packs eight serial nibbles, kicks the range-sum stage, captures its sum.
// Define LOADER_RANGE_SORT_EN to present the smaller range bound on m_out and the larger on big_m_out.
module range_operand_loader #(
    parameter int NIB_W       = 4,
    parameter int NIB_N       = 8,
    parameter int WAIT_CYCLES = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [NIB_W-1:0]       in_data,
    output logic                   in_ready,
    input  logic [2:0]             lo_idx,
    input  logic [2:0]             hi_idx,
    output logic [NIB_W*NIB_N-1:0] word_out,
    output logic [2:0]             m_out,
    output logic [2:0]             big_m_out,
    output logic                   kick,
    input  logic [7:0]             sum_in,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    input  logic                   out_ready
);
    localparam int WC_W = $clog2(WAIT_CYCLES);
    typedef enum logic [1:0] {LOAD, KICK, WAIT, HOLD} state_t;
    state_t                   state_q, state_d;
    logic [2:0]               cnt_q, cnt_d;
    logic [NIB_W*NIB_N-1:0]   word_q, word_d;
    logic [2:0]               m_q, m_d, bm_q, bm_d;
    logic [WC_W-1:0]          wait_q, wait_d;
    logic [7:0]               data_q, data_d;
    logic [2:0]               lo_s, hi_s;
`ifdef LOADER_RANGE_SORT_EN
    assign lo_s = (hi_idx < lo_idx) ? hi_idx : lo_idx;
    assign hi_s = (hi_idx < lo_idx) ? lo_idx : hi_idx;
`else
    assign lo_s = lo_idx;
    assign hi_s = hi_idx;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        m_d     = m_q;
        bm_d    = bm_q;
        wait_d  = wait_q;
        data_d  = data_q;
        unique case (state_q)
            LOAD: if (in_valid) begin
                word_d[cnt_q*NIB_W +: NIB_W] = in_data;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(NIB_N-1)) begin
                    m_d     = lo_s;
                    bm_d    = hi_s;
                    cnt_d   = '0;
                    state_d = KICK;
                end
            end
            KICK: begin
                wait_d  = WC_W'(WAIT_CYCLES-1);
                state_d = WAIT;
            end
            WAIT: if (wait_q == '0) begin
                data_d  = sum_in;
                state_d = HOLD;
            end else begin
                wait_d = wait_q - WC_W'(1);
            end
            HOLD: state_d = out_ready ? LOAD : HOLD;
            default: state_d = LOAD;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            word_q  <= '0;
            m_q     <= '0;
            bm_q    <= '0;
            wait_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            m_q     <= m_d;
            bm_q    <= bm_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
        end
    end
    // Handshake and kick decode straight from state so reset clears them immediately.
    assign in_ready  = state_q == LOAD;
    assign kick      = state_q == KICK;
    assign out_valid = state_q == HOLD;
    assign word_out  = word_q;
    assign m_out     = m_q;
    assign big_m_out = bm_q;
    assign out_data  = data_q;
endmodule

// File: tb/tb_range_operand_loader.sv
// tb_range_operand_loader: directed bench with a behavioural summing stage and a scoreboard of expected sums.
module tb_range_operand_loader;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [3:0]  in_data = 0;
    logic [2:0]  lo_idx = 0, hi_idx = 0;
    logic        in_ready, kick, out_valid;
    logic [31:0] word_out;
    logic [2:0]  m_out, big_m_out;
    logic [7:0]  sum_in, out_data;
    int          n_vec = 0, n_err = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    range_operand_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .lo_idx(lo_idx), .hi_idx(hi_idx), .word_out(word_out), .m_out(m_out),
        .big_m_out(big_m_out), .kick(kick), .sum_in(sum_in), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready)
    );

    function automatic logic [7:0] range_sum(input logic [31:0] w, input logic [2:0] a, input logic [2:0] b);
        logic [7:0] s = '0;
        for (int k = 0; k < 8; k++)
            if ((k >= int'(a) && k <= int'(b)) || (k >= int'(b) && k <= int'(a))) s += 8'(w[4*k +: 4]);
        return s;
    endfunction

    // Stand-in for the summing stage, fed from the loader's outputs.
    assign sum_in = range_sum(word_out, m_out, big_m_out);

    function automatic logic [2:0] exp_m(input logic [2:0] lo, input logic [2:0] hi);
`ifdef LOADER_RANGE_SORT_EN
        return (hi < lo) ? hi : lo;
`else
        return lo;
`endif
    endfunction

    function automatic logic [2:0] exp_bm(input logic [2:0] lo, input logic [2:0] hi);
`ifdef LOADER_RANGE_SORT_EN
        return (hi < lo) ? lo : hi;
`else
        return hi;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] d);
        int n = 0;
        in_valid = 1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", n, 0);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic load(input logic [31:0] w, input logic [2:0] lo, input logic [2:0] hi, input int from, input bit gap);
        lo_idx = lo;
        hi_idx = hi;
        for (int k = from; k < 8; k++) begin
            if (k == 7) exp_q.push_back(range_sum(w, lo, hi));
            send(w[4*k +: 4]);
            if (gap && k < 7) begin
                in_data = ~w[4*k +: 4];
                @(negedge clk);
            end
        end
    endtask

    task automatic finish_word(input logic [31:0] w, input logic [2:0] lo, input logic [2:0] hi, input int hold);
        int n;
        logic [7:0] d;
        chk("kick_on", 32'(kick), 1);
        chk("in_ready_kick", 32'(in_ready), 0);
        chk("word_out", word_out, w);
        chk("m_out", 32'(m_out), 32'(exp_m(lo, hi)));
        chk("big_m_out", 32'(big_m_out), 32'(exp_bm(lo, hi)));
        @(negedge clk);
        n = 1;
        chk("kick_off", 32'(kick), 0);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 11);
        chk("word_stable", word_out, w);
        d = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        chk("out_data", 32'(out_data), 32'(d));
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", 32'(out_data), 32'(d));
            chk("hold_in_ready", 32'(in_ready), 0);
        end
    endtask

    task automatic release_out();
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("valid_drop", 32'(out_valid), 0);
        chk("in_ready_back", 32'(in_ready), 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_word", word_out, 0);
        chk("rst_m", 32'(m_out), 0);
        chk("rst_bm", 32'(big_m_out), 0);
        chk("rst_kick", 32'(kick), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        chk_reset_vals();
        chk("rst_in_ready", 32'(in_ready), 1);

        load(32'h87654321, 3'd2, 3'd5, 0, 0);
        finish_word(32'h87654321, 3'd2, 3'd5, 0);
        release_out();

        load(32'h87654321, 3'd5, 3'd2, 0, 0);
        finish_word(32'h87654321, 3'd5, 3'd2, 0);
        release_out();

        load(32'hFFFFFFFF, 3'd0, 3'd7, 0, 0);
        finish_word(32'hFFFFFFFF, 3'd0, 3'd7, 0);
        chk("max_sum", 32'(out_data), 32'h78);
        release_out();

        load(32'h2468ACE6, 3'd1, 3'd6, 0, 1);
        finish_word(32'h2468ACE6, 3'd1, 3'd6, 5);
        in_valid  = 1;
        in_data   = 4'h9;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("valid_drop_busy", 32'(out_valid), 0);
        chk("in_ready_rise", 32'(in_ready), 1);
        chk("slot0_not_taken", 32'(word_out[3:0]), 32'h6);
        @(negedge clk);
        in_valid = 0;
        chk("slot0_taken", 32'(word_out[3:0]), 32'h9);
        load(32'h0F1E2D39, 3'd7, 3'd0, 1, 0);
        finish_word(32'h0F1E2D39, 3'd7, 3'd0, 0);
        release_out();

        lo_idx = 3'd4;
        hi_idx = 3'd6;
        for (int k = 0; k < 4; k++) send(4'hC);
        chk("partial_word", word_out[15:0], 32'hCCCC);
        rst = 1;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst = 0;
        chk("rst_in_ready2", 32'(in_ready), 1);
        load(32'h13572468, 3'd3, 3'd3, 0, 0);
        finish_word(32'h13572468, 3'd3, 3'd3, 0);
        chk("equal_bounds", 32'(out_data), 32'h2);
        release_out();

        load(32'h11111111, 3'd0, 3'd1, 0, 0);
        chk("kick_before_rst", 32'(kick), 1);
        rst = 1;
        #1;
        chk("kick_async_drop", 32'(kick), 0);
        chk_reset_vals();
        exp_q.delete();
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("no_stale_valid", 32'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
